// File: rtl/text_splitter.sv
// text_splitter: buffers packed text words, serializes them a byte per cycle, lowercases
// letters and collapses non-alphanumerics into single 0x00 word delimiters.
module text_splitter #(
    parameter int LETTER_SIZE  = 8,
    parameter int IN_WIDTH     = 32,
    parameter int FIFO_DEPTH   = 4,
    parameter int MAX_WORD_LEN = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [IN_WIDTH-1:0]    in_data,
    input  logic                   in_last,
    output logic                   letter_valid,
    output logic [LETTER_SIZE-1:0] letter_out,
    output logic [15:0]            word_cnt,
    output logic [7:0]             trunc_cnt,
    output logic                   done
);
    localparam int BYTES = IN_WIDTH / LETTER_SIZE;
    localparam int IW    = BYTES > 1 ? $clog2(BYTES) : 1;
    localparam int AW    = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
    localparam int LW    = $clog2(MAX_WORD_LEN + 1);

    typedef enum logic [1:0] {IDLE, SERIAL, FLUSH, DONE} state_t;
    state_t state, state_n;

    logic [IN_WIDTH:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [AW:0]           count;
    logic                  push, pop, empty, full;
    logic [IN_WIDTH-1:0]   sreg;
    logic                  slast;
    logic [IW-1:0]         idx;
    logic [LW-1:0]         wlen;
    logic                  trunc_mark;
    logic [LETTER_SIZE-1:0] cur, lc;
    logic                  last_byte, proc, is_upper, is_alnum, letter, delim, room;
    logic                  emit_letter, emit_delim;

    assign empty    = count == '0;
    assign full     = count == (AW+1)'(FIFO_DEPTH);
    assign in_ready = rst & ~clr & ~full;
    assign push     = in_valid & in_ready;

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= {in_last, in_data};

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + (AW+1)'(push) - (AW+1)'(pop);
        end

    // byte classification of the serializer's current byte
    assign cur       = sreg[idx*LETTER_SIZE +: LETTER_SIZE];
    assign last_byte = idx == IW'(BYTES - 1);
    assign proc      = state == SERIAL;
    assign is_upper  = cur >= LETTER_SIZE'('h41) && cur <= LETTER_SIZE'('h5A);
    assign is_alnum  = is_upper || (cur >= LETTER_SIZE'('h61) && cur <= LETTER_SIZE'('h7A)) ||
                       (cur >= LETTER_SIZE'('h30) && cur <= LETTER_SIZE'('h39));
    assign lc        = is_upper ? cur + LETTER_SIZE'('h20) : cur;
    assign letter    = proc & is_alnum;
    assign delim     = (proc & ~is_alnum) | (state == FLUSH);
    assign room      = wlen < LW'(MAX_WORD_LEN);
    assign emit_letter = letter & room;
    assign emit_delim  = delim & (wlen != '0);

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else state <= state_n;

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        unique case (state)
            IDLE: if (!empty) begin
                pop     = 1'b1;
                state_n = SERIAL;
            end
            SERIAL: if (last_byte) begin
                if (slast) state_n = FLUSH;
                else if (!empty) pop = 1'b1;
                else state_n = IDLE;
            end
            FLUSH: state_n = DONE;
            DONE: begin
                pop     = !empty;
                state_n = empty ? IDLE : SERIAL;
            end
            default: state_n = IDLE;
        endcase
        if (clr) begin
            state_n = IDLE;
            pop     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            sreg         <= '0;
            slast        <= 1'b0;
            idx          <= '0;
            wlen         <= '0;
            trunc_mark   <= 1'b0;
            word_cnt     <= '0;
            trunc_cnt    <= '0;
            letter_valid <= 1'b0;
            letter_out   <= '0;
            done         <= 1'b0;
        end else if (clr) begin
            sreg         <= '0;
            slast        <= 1'b0;
            idx          <= '0;
            wlen         <= '0;
            trunc_mark   <= 1'b0;
            word_cnt     <= '0;
            trunc_cnt    <= '0;
            letter_valid <= 1'b0;
            letter_out   <= '0;
            done         <= 1'b0;
        end else begin
            if (pop) begin
                sreg  <= mem[rd_ptr][IN_WIDTH-1:0];
                slast <= mem[rd_ptr][IN_WIDTH];
                idx   <= '0;
            end else if (proc) begin
                idx <= idx + IW'(1);
            end
            if (emit_letter) wlen <= wlen + LW'(1);
            if (letter & ~room) trunc_mark <= 1'b1;
            if (emit_delim) begin
                wlen       <= '0;
                trunc_mark <= 1'b0;
                word_cnt   <= word_cnt + 16'(word_cnt != '1);
                if (trunc_mark) trunc_cnt <= trunc_cnt + 8'(trunc_cnt != '1);
            end
            letter_valid <= emit_letter | emit_delim;
            letter_out   <= emit_letter ? lc : '0;
            done         <= state == DONE;
        end
endmodule
